// File: rtl/spi_reg_seq.sv
// Register-access sequencer in front of the 3-wire SPI byte engine.
// Turns one R/W request into instruction-hi, instruction-lo and data chunks.
module spi_reg_seq #(
    parameter int ADDR_W  = 13,
    parameter int TIMEOUT = 32,
    parameter int TO_W    = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic [7:0]        chunk_data_o,
    output logic              chunk_read_o,
    output logic              chunk_start_o,
    input  logic [7:0]        chunk_data_i,
    input  logic              chunk_busy_i,
    input  logic              chunk_finish_i
);

    typedef enum logic [2:0] {
        IDLE,
        INST_HI,
        INST_LO,
        DATA,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic            wr_q, wr_d;
    logic [7:0]      inst_lo_q, inst_lo_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [TO_W-1:0] to_inc;
    logic            to_hit;
    logic            start_q, start_d;
    logic [7:0]      cdata_q, cdata_d;
    logic            cread_q, cread_d;
    logic [15:0]     req_inst;

    // Bit 15 flags a read; bits 14:13 are the length field (one byte).
    assign req_inst = {~req_write, 2'b00, 13'(req_addr)};
    assign to_inc   = to_q + 1'b1;
    assign to_hit   = (to_inc == TO_W'(TIMEOUT - 1));

    assign chunk_start_o = start_q;
    assign chunk_data_o  = cdata_q;
    assign chunk_read_o  = cread_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            inst_lo_q <= 8'h00;
            wdata_q   <= 8'h00;
            err_q     <= 1'b0;
            to_q      <= '0;
            start_q   <= 1'b0;
            cdata_q   <= 8'h00;
            cread_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            inst_lo_q <= inst_lo_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            to_q      <= to_d;
            start_q   <= start_d;
            cdata_q   <= cdata_d;
            cread_q   <= cread_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        inst_lo_d = inst_lo_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        to_d      = to_q;
        start_d   = 1'b0;
        cdata_d   = cdata_q;
        cread_d   = cread_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    wr_d      = req_write;
                    inst_lo_d = req_inst[7:0];
                    wdata_d   = req_wdata;
                    err_d     = 1'b0;
                    to_d      = '0;
                    start_d   = 1'b1;
                    cdata_d   = req_inst[15:8];
                    cread_d   = 1'b0;
                    state_d   = INST_HI;
                end
            end
            INST_HI: begin
                if (chunk_finish_i) begin
                    to_d    = '0;
                    start_d = 1'b1;
                    cdata_d = inst_lo_q;
                    cread_d = 1'b0;
                    state_d = INST_LO;
                end else begin
                    to_d = to_inc;
                    if (to_hit) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            INST_LO: begin
                if (chunk_finish_i) begin
                    to_d    = '0;
                    start_d = 1'b1;
                    cdata_d = wr_q ? wdata_q : 8'h00;
                    cread_d = ~wr_q;
                    state_d = DATA;
                end else begin
                    to_d = to_inc;
                    if (to_hit) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            DATA: begin
                if (chunk_finish_i) begin
                    state_d = RESP;
                end else begin
                    to_d = to_inc;
                    if (to_hit) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready is held low while reset is applied so every output reads 0.
    always_comb begin
        req_ready = RST && (state_q == IDLE) && !chunk_busy_i;
        rsp_valid = (state_q == RESP);
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = 8'h00;
        if (rsp_valid && !wr_q && !err_q) begin
            rsp_rdata = chunk_data_i;
        end
    end

endmodule

// File: tb/tb_spi_reg_seq.sv
// Directed bench for spi_reg_seq with a cycle-level SPI byte engine model.
// Checks chunk bytes, start spacing, latency, timeout and async reset.
module tb_spi_reg_seq;

    localparam int TIMEOUT = 32;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [12:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [7:0]  chunk_data_o;
    logic        chunk_read_o;
    logic        chunk_start_o;
    logic [7:0]  chunk_data_i;
    logic        chunk_busy_i;
    logic        chunk_finish_i;

    always #5 CLK = ~CLK;

    spi_reg_seq #(
        .ADDR_W (13),
        .TIMEOUT(TIMEOUT),
        .TO_W   (6)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .chunk_data_o  (chunk_data_o),
        .chunk_read_o  (chunk_read_o),
        .chunk_start_o (chunk_start_o),
        .chunk_data_i  (chunk_data_i),
        .chunk_busy_i  (chunk_busy_i),
        .chunk_finish_i(chunk_finish_i)
    );

    // Engine model: finish strobe 17 cycles after the start cycle.
    logic       e_busy;
    logic       e_fin;
    logic [4:0] e_cnt;
    logic       e_rd;
    logic [7:0] e_data;
    int         e_n = 0;
    int         mute_at = -1;
    logic [7:0] rd_val = 8'h00;

    assign chunk_busy_i   = e_busy;
    assign chunk_finish_i = e_fin;
    assign chunk_data_i   = e_data;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            e_busy <= 1'b0;
            e_fin  <= 1'b0;
            e_cnt  <= '0;
            e_rd   <= 1'b0;
            e_data <= 8'h00;
        end else begin
            e_fin <= 1'b0;
            if (chunk_start_o) begin
                e_n <= e_n + 1;
                if (e_n != mute_at) begin
                    e_busy <= 1'b1;
                    e_cnt  <= 5'd1;
                    e_rd   <= chunk_read_o;
                end
            end else if (e_fin) begin
                e_busy <= 1'b0;
            end else if (e_busy) begin
                e_cnt <= e_cnt + 5'd1;
                if (e_cnt == 5'd16) begin
                    e_fin  <= 1'b1;
                    e_data <= e_rd ? rd_val : 8'hEE;
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int         acc_c[$];
    int         fin_c[$];
    int         st_c[$];
    logic [7:0] st_d[$];
    logic       st_r[$];
    int         rs_c[$];
    logic [7:0] rs_d[$];
    logic       rs_e[$];

    always @(negedge CLK) begin
        if (RST && req_valid && req_ready) acc_c.push_back(cyc);
        if (chunk_finish_i) fin_c.push_back(cyc);
        if (chunk_start_o) begin
            st_c.push_back(cyc);
            st_d.push_back(chunk_data_o);
            st_r.push_back(chunk_read_o);
        end
        if (rsp_valid) begin
            rs_c.push_back(cyc);
            rs_d.push_back(rsp_rdata);
            rs_e.push_back(rsp_err);
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic w, input logic [12:0] a,
                        input logic [7:0] d);
        int n0;
        n0 = acc_c.size();
        @(posedge CLK); #1;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK); #1;
            if (acc_c.size() != n0) break;
        end
        chk("accept", acc_c.size() - n0, 1);
        @(posedge CLK); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK); #1;
            if (rs_c.size() >= n) break;
        end
        chk("rsp_seen", rs_c.size() >= n, 1);
        repeat (4) @(negedge CLK);
    endtask

    task automatic chk_txn(input string tag, input int b, input int r,
                           input logic [23:0] bytes, input logic [2:0] rds,
                           input logic [7:0] rdata);
        chk({tag, "_nst"}, st_c.size() - b, 3);
        chk({tag, "_bytes"}, {st_d[b], st_d[b+1], st_d[b+2]}, bytes);
        chk({tag, "_rd"}, {st_r[b], st_r[b+1], st_r[b+2]}, rds);
        chk({tag, "_nrsp"}, rs_c.size() - r, 1);
        chk({tag, "_rsp"}, {rs_d[r], rs_e[r]}, {rdata, 1'b0});
    endtask

    int b, r, k, f;

    initial begin
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge CLK);
        chk("rst_outs", {req_ready, rsp_valid, rsp_err, rsp_rdata,
                         chunk_start_o, chunk_read_o, chunk_data_o}, 0);
        RST = 1'b1;
        @(negedge CLK); #1;
        chk("idle_ready", req_ready, 1);

        // write 0x0A5 / 0x3C
        b = st_c.size(); r = rs_c.size(); k = acc_c.size(); f = fin_c.size();
        send(1'b1, 13'h0A5, 8'h3C);
        wait_rsp(r + 1);
        chk_txn("wr1", b, r, 24'h00A53C, 3'b000, 8'h00);
        chk("wr1_first", st_c[b] - acc_c[k], 1);
        chk("wr1_gap1", st_c[b+1] - fin_c[f], 1);
        chk("wr1_gap2", st_c[b+2] - fin_c[f+1], 1);
        chk("wr1_lat", rs_c[r] - acc_c[k], 55);

        // read 0x1FFF -> 0x5A
        rd_val = 8'h5A;
        b = st_c.size(); r = rs_c.size();
        send(1'b0, 13'h1FFF, 8'hA7);
        wait_rsp(r + 1);
        chk_txn("rd1", b, r, 24'h9FFF00, 3'b001, 8'h5A);

        // write 0x123 / 0x81
        b = st_c.size(); r = rs_c.size();
        send(1'b1, 13'h123, 8'h81);
        wait_rsp(r + 1);
        chk_txn("wr2", b, r, 24'h012381, 3'b000, 8'h00);

        // request held across two transactions
        b = st_c.size(); r = rs_c.size(); k = acc_c.size();
        @(posedge CLK); #1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 13'h055;
        req_wdata = 8'h77;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK); #1;
            if (acc_c.size() >= k + 2) break;
        end
        @(posedge CLK); #1;
        req_valid = 1'b0;
        wait_rsp(r + 2);
        chk("bb_nacc", acc_c.size() - k, 2);
        chk("bb_acc2", acc_c[k+1] - rs_c[r], 1);
        chk("bb_start", st_c[b+3] - acc_c[k+1], 1);
        chk("bb_nst", st_c.size() - b, 6);
        chk("bb_bytes", {st_d[b+3], st_d[b+4], st_d[b+5]}, 24'h005577);

        // engine ignores the INST_LO start
        rd_val  = 8'h44;
        mute_at = e_n + 1;
        b = st_c.size(); r = rs_c.size();
        send(1'b0, 13'h010, 8'h00);
        wait_rsp(r + 1);
        repeat (40) @(negedge CLK);
        mute_at = -1;
        chk("to_nst", st_c.size() - b, 2);
        chk("to_nrsp", rs_c.size() - r, 1);
        chk("to_rsp", {rs_d[r], rs_e[r]}, {8'h00, 1'b1});
        chk("to_lat", rs_c[r] - st_c[b+1], TIMEOUT - 1);

        rd_val = 8'hC3;
        b = st_c.size(); r = rs_c.size();
        send(1'b0, 13'h002, 8'h00);
        wait_rsp(r + 1);
        chk_txn("rd2", b, r, 24'h800200, 3'b001, 8'hC3);

        // async reset during the data byte
        b = st_c.size(); r = rs_c.size();
        send(1'b1, 13'h0F0, 8'h5F);
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK); #1;
            if (st_c.size() >= b + 3) break;
        end
        chk("rst_reach_data", st_c.size() - b, 3);
        repeat (5) @(negedge CLK);
        #1 RST = 1'b0;
        #1;
        chk("rst_mid", {req_ready, rsp_valid, rsp_err, rsp_rdata,
                        chunk_start_o, chunk_read_o, chunk_data_o}, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (40) @(negedge CLK);
        chk("rst_norsp", rs_c.size() - r, 0);

        rd_val = 8'h99;
        b = st_c.size(); r = rs_c.size();
        send(1'b0, 13'h1AB, 8'h00);
        wait_rsp(r + 1);
        chk_txn("rd3", b, r, 24'h81AB00, 3'b001, 8'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
